hamming_ext_rx_packer: RTL

Streaming receive stage directly downstream of hamming_decoder_ext. It accepts 8-bit eH(8,4) codewords over a valid/ready handshake and decodes each one with the existing combinational decoder. Pairs of decoded nibbles are packed into bytes, with the low nibble arriving first. Each byte leaves through a registered valid/ready output carrying per-byte error flags, and saturating error counters are maintained for status readout.

---
 rtl/hamming_ext_pkg.sv | 12 +
 rtl/hamming_decoder_ext.sv | 36 +++
 rtl/hamming_ext_rx_packer.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/hamming_ext_pkg.sv
// Shared widths and packer state encoding for the extended-Hamming receive path.
package hamming_ext_pkg;

    localparam int unsigned CODEWORD_W = 8;
    localparam int unsigned DATA_W     = 4;

    typedef enum logic {
        EMPTY,
        HALF
    } pack_state_t;

endpackage

// File: rtl/hamming_decoder_ext.sv
// Combinational eH(8,4) decoder: bits [6:0] are Hamming positions 1..7, bit 7 is overall parity.
// Data sits at positions 3,5,6,7; single errors are corrected, double errors are flagged.
module hamming_decoder_ext
    import hamming_ext_pkg::*;
(
    input  logic [CODEWORD_W-1:0] codeword_in,
    output logic [DATA_W-1:0]     data_out,
    output logic                  correctable_error,
    output logic                  uncorrectable_error
);

    logic [2:0] syndrome;
    logic       overall;
    logic [6:0] fixed;

    always_comb begin
        syndrome[0] = codeword_in[0] ^ codeword_in[2] ^ codeword_in[4] ^ codeword_in[6];
        syndrome[1] = codeword_in[1] ^ codeword_in[2] ^ codeword_in[5] ^ codeword_in[6];
        syndrome[2] = codeword_in[3] ^ codeword_in[4] ^ codeword_in[5] ^ codeword_in[6];
        overall     = ^codeword_in;

        // Odd overall parity means one flipped bit; zero syndrome puts it in bit 7.
        correctable_error   = overall;
        uncorrectable_error = !overall && (syndrome != 3'd0);

        fixed = codeword_in[6:0];
        for (int i = 0; i < 7; i++) begin
            if (overall && (syndrome == 3'(i + 1))) begin
                fixed[i] = ~fixed[i];
            end
        end

        data_out = {fixed[6], fixed[5], fixed[4], fixed[2]};
    end

endmodule

// File: rtl/hamming_ext_rx_packer.sv
// Receive packer: decodes eH(8,4) codewords and packs nibble pairs (low first) into bytes,
// with per-byte error flags on a registered valid/ready output and saturating error counters.
module hamming_ext_rx_packer
    import hamming_ext_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CODEWORD_W-1:0] in_codeword,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [7:0]            out_byte,
    output logic                  out_corrected,
    output logic                  out_uncorrectable,
    output logic                  half_pending,
    input  logic                  flush,
    input  logic                  clr_counters,
    output logic [CNT_W-1:0]      cnt_corrected,
    output logic [CNT_W-1:0]      cnt_uncorrectable
);

    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    logic [DATA_W-1:0] dec_data;
    logic              dec_corr;
    logic              dec_unc;
    logic              accept;

    pack_state_t       state_q, state_d;
    logic [DATA_W-1:0] held_data_q, held_data_d;
    logic              held_corr_q, held_corr_d;
    logic              held_unc_q, held_unc_d;
    logic              out_valid_q, out_valid_d;
    logic [7:0]        out_byte_q, out_byte_d;
    logic              out_corr_q, out_corr_d;
    logic              out_unc_q, out_unc_d;
    logic [CNT_W-1:0]  cnt_corr_q, cnt_corr_d;
    logic [CNT_W-1:0]  cnt_unc_q, cnt_unc_d;

    hamming_decoder_ext u_decoder (
        .codeword_in         (in_codeword),
        .data_out            (dec_data),
        .correctable_error   (dec_corr),
        .uncorrectable_error (dec_unc)
    );

    // A byte can load in the same cycle the previous one drains.
    assign in_ready = !flush && ((state_q == EMPTY) || !out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        held_data_d = held_data_q;
        held_corr_d = held_corr_q;
        held_unc_d  = held_unc_q;
        out_valid_d = out_valid_q;
        out_byte_d  = out_byte_q;
        out_corr_d  = out_corr_q;
        out_unc_d   = out_unc_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (flush) begin
            state_d     = EMPTY;
            held_data_d = '0;
            held_corr_d = 1'b0;
            held_unc_d  = 1'b0;
        end else if (accept) begin
            unique case (state_q)
                EMPTY: begin
                    held_data_d = dec_data;
                    held_corr_d = dec_corr;
                    held_unc_d  = dec_unc;
                    state_d     = HALF;
                end
                HALF: begin
                    out_byte_d  = {dec_data, held_data_q};
                    out_corr_d  = dec_corr || held_corr_q;
                    out_unc_d   = dec_unc || held_unc_q;
                    out_valid_d = 1'b1;
                    state_d     = EMPTY;
                end
            endcase
        end
    end

    always_comb begin
        cnt_corr_d = cnt_corr_q;
        cnt_unc_d  = cnt_unc_q;
        if (clr_counters) begin
            cnt_corr_d = '0;
            cnt_unc_d  = '0;
        end else if (accept) begin
            if (dec_corr && (cnt_corr_q != CntMax)) begin
                cnt_corr_d = cnt_corr_q + CntOne;
            end
            if (dec_unc && (cnt_unc_q != CntMax)) begin
                cnt_unc_d = cnt_unc_q + CntOne;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= EMPTY;
            held_data_q <= '0;
            held_corr_q <= 1'b0;
            held_unc_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_byte_q  <= '0;
            out_corr_q  <= 1'b0;
            out_unc_q   <= 1'b0;
            cnt_corr_q  <= '0;
            cnt_unc_q   <= '0;
        end else begin
            state_q     <= state_d;
            held_data_q <= held_data_d;
            held_corr_q <= held_corr_d;
            held_unc_q  <= held_unc_d;
            out_valid_q <= out_valid_d;
            out_byte_q  <= out_byte_d;
            out_corr_q  <= out_corr_d;
            out_unc_q   <= out_unc_d;
            cnt_corr_q  <= cnt_corr_d;
            cnt_unc_q   <= cnt_unc_d;
        end
    end

    assign out_valid         = out_valid_q;
    assign out_byte          = out_byte_q;
    assign out_corrected     = out_corr_q;
    assign out_uncorrectable = out_unc_q;
    assign half_pending      = (state_q == HALF);
    assign cnt_corrected     = cnt_corr_q;
    assign cnt_uncorrectable = cnt_unc_q;

endmodule
